// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_mem_pkg
// Description : Shared codes for the MEM stage: access widths, FSM states and
//               byte-lane enable patterns.
// Revision    : 1.0
// ============================================================================
package mips_mem_pkg;

  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b10;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

endpackage
`default_nettype wire

// File: rtl/memory_access_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : memory_access_stage_if
// Description : Request/acknowledge data-memory port between MEM stage and memory.
// Revision    : 1.0
// ============================================================================
interface memory_access_stage_if #(
  parameter int NB_DATA = 32
);
  logic               req;
  logic               we;
  logic [NB_DATA-1:0] addr;
  logic [3:0]         be;
  logic [NB_DATA-1:0] wdata;
  logic               ack;
  logic [NB_DATA-1:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output ack, rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_lane_align
// Description : Combinational byte/half/word lane steering for stores and
//               lane selection plus sign/zero extension for loads.
// Revision    : 1.0
// ============================================================================
module mem_lane_align
  import mips_mem_pkg::*;
#(
  parameter int NB_DATA = 32
) (
  input  logic [1:0]         addr_lo,
  input  logic [1:0]         width,
  input  logic               sign,
  input  logic [NB_DATA-1:0] wdata,
  input  logic [NB_DATA-1:0] rdata,
  output logic [3:0]         be,
  output logic [NB_DATA-1:0] wdata_rep,
  output logic [NB_DATA-1:0] rdata_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel  = rdata[8*addr_lo +: 8];
    half_sel  = addr_lo[1] ? rdata[NB_DATA-1:16] : rdata[15:0];
    be        = BE_WORD;
    wdata_rep = wdata;
    rdata_ext = rdata;
    case (width)
      WIDTH_BYTE: begin
        be        = BE_BYTE0 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{(NB_DATA-8){sign & byte_sel[7]}}, byte_sel};
      end
      WIDTH_HALF: begin
        // Half accesses only look at addr[1]; addr[0] is handled upstream.
        be        = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{(NB_DATA-16){sign & half_sel[15]}}, half_sel};
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/memory_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : memory_access_stage
// Description : MIPS MEM stage: req/ack data-memory access, lane steering and
//               MEM/WB register. Optional macro MEM_MISALIGN_TRAP_EN adds
//               misaligned-access trapping with output o_misaligned.
// Revision    : 1.0
// ============================================================================
module memory_access_stage
  import mips_mem_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5
) (
  input  logic                 clk,
  input  logic                 i_rst_n,
  input  logic                 i_halt,
  input  logic                 i_mem2reg,
  input  logic                 i_memRead,
  input  logic                 i_memWrite,
  input  logic                 i_regWrite,
  input  logic [1:0]           i_width,
  input  logic                 i_sign_flag,
  input  logic [NB_REG-1:0]    i_write_reg,
  input  logic [NB_DATA-1:0]   i_result,
  input  logic [NB_DATA-1:0]   i_data4Mem,
  memory_access_stage_if.master dm,
  output logic                 o_stall,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic                 o_misaligned,
`endif
  output logic                 o_mem2reg,
  output logic                 o_regWrite,
  output logic [NB_REG-1:0]    o_write_reg,
  output logic [NB_DATA-1:0]   o_alu_result,
  output logic [NB_DATA-1:0]   o_read_data
);

  logic [0:0]         state;
  logic [0:0]         state_nxt;
  logic               access;
  logic               misaligned;
  logic               idle_go;
  logic               start;
  logic               stall;
  logic               wb_load;
  logic [3:0]         lane_be;
  logic [NB_DATA-1:0] lane_wdata;
  logic [NB_DATA-1:0] lane_rdata;

  logic               req_q;
  logic               we_q;
  logic [NB_DATA-1:0] addr_q;
  logic [3:0]         be_q;
  logic [NB_DATA-1:0] wdata_q;

  assign access  = i_memRead | i_memWrite;
  assign idle_go = (state == IDLE) && !i_halt;
  assign start   = idle_go && access && !misaligned;

`ifdef MEM_MISALIGN_TRAP_EN
  logic misaligned_q;

  assign misaligned = access &&
                      (((i_width == WIDTH_HALF) && i_result[0]) ||
                       (i_width[1] && (i_result[1:0] != 2'b00)));
  assign o_misaligned = misaligned_q;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) misaligned_q <= 1'b0;
    else          misaligned_q <= idle_go && misaligned;
  end
`else
  assign misaligned = 1'b0;
`endif

  mem_lane_align #(
    .NB_DATA (NB_DATA)
  ) u_lane (
    .addr_lo   (i_result[1:0]),
    .width     (i_width),
    .sign      (i_sign_flag),
    .wdata     (i_data4Mem),
    .rdata     (dm.rdata),
    .be        (lane_be),
    .wdata_rep (lane_wdata),
    .rdata_ext (lane_rdata)
  );

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)  state_nxt = BUSY;
      BUSY:    if (dm.ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stall   = 1'b0;
    wb_load = 1'b0;
    case (state)
      IDLE: begin
        stall   = start;
        wb_load = idle_go && !start;
      end
      BUSY: begin
        stall   = !dm.ack;
        wb_load = dm.ack;
      end
      default: ;
    endcase
  end

  assign o_stall = stall;

  // Bus fields are captured once at launch and held until the ack.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= BE_NONE;
      wdata_q <= '0;
    end else if (start) begin
      req_q   <= 1'b1;
      we_q    <= i_memWrite;
      addr_q  <= {i_result[NB_DATA-1:2], 2'b00};
      be_q    <= i_memWrite ? lane_be : BE_NONE;
      wdata_q <= lane_wdata;
    end else if ((state == BUSY) && dm.ack) begin
      req_q   <= 1'b0;
    end
  end

  assign dm.req   = req_q;
  assign dm.we    = we_q;
  assign dm.addr  = addr_q;
  assign dm.be    = be_q;
  assign dm.wdata = wdata_q;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_mem2reg    <= 1'b0;
      o_regWrite   <= 1'b0;
      o_write_reg  <= '0;
      o_alu_result <= '0;
      o_read_data  <= '0;
    end else if (wb_load) begin
      o_mem2reg    <= i_mem2reg;
      o_regWrite   <= i_regWrite && !misaligned;
      o_write_reg  <= i_write_reg;
      o_alu_result <= i_result;
      o_read_data  <= ((state == BUSY) && !we_q) ? lane_rdata : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_access_stage
// Description : Scoreboard bench for memory_access_stage (MEM_MISALIGN_TRAP_EN aware).
// Revision    : 1.0
// ============================================================================
module tb_memory_access_stage;
  import mips_mem_pkg::*;

  typedef struct packed {
    logic        m2r;
    logic        rw;
    logic [4:0]  wr;
    logic [31:0] alu;
    logic [31:0] rd;
  } wb_t;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_halt;
  logic        i_mem2reg;
  logic        i_memRead;
  logic        i_memWrite;
  logic        i_regWrite;
  logic [1:0]  i_width;
  logic        i_sign_flag;
  logic [4:0]  i_write_reg;
  logic [31:0] i_result;
  logic [31:0] i_data4Mem;
  logic        o_stall;
  logic        o_mem2reg;
  logic        o_regWrite;
  logic [4:0]  o_write_reg;
  logic [31:0] o_alu_result;
  logic [31:0] o_read_data;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        o_misaligned;
`endif

  int  checks   = 0;
  int  failures = 0;
  wb_t exp_q[$];
  wb_t cur_wb;
  wb_t prev_wb;

  memory_access_stage_if #(.NB_DATA(32)) dm();

  always #5 clk = ~clk;

  memory_access_stage #(.NB_DATA(32), .NB_REG(5)) dut (
    .clk          (clk),
    .i_rst_n      (i_rst_n),
    .i_halt       (i_halt),
    .i_mem2reg    (i_mem2reg),
    .i_memRead    (i_memRead),
    .i_memWrite   (i_memWrite),
    .i_regWrite   (i_regWrite),
    .i_width      (i_width),
    .i_sign_flag  (i_sign_flag),
    .i_write_reg  (i_write_reg),
    .i_result     (i_result),
    .i_data4Mem   (i_data4Mem),
    .dm           (dm),
    .o_stall      (o_stall),
`ifdef MEM_MISALIGN_TRAP_EN
    .o_misaligned (o_misaligned),
`endif
    .o_mem2reg    (o_mem2reg),
    .o_regWrite   (o_regWrite),
    .o_write_reg  (o_write_reg),
    .o_alu_result (o_alu_result),
    .o_read_data  (o_read_data)
  );

  assign cur_wb = {o_mem2reg, o_regWrite, o_write_reg, o_alu_result, o_read_data};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every MEM/WB change is matched against the oldest expectation.
  initial begin
    wb_t e;
    prev_wb = '0;
    forever begin
      @(negedge clk);
      if (i_rst_n && (cur_wb !== prev_wb)) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_wb actual=%h required=none", cur_wb);
        end else begin
          e = exp_q.pop_front();
          chk("wb_mem2reg", 32'(o_mem2reg), 32'(e.m2r));
          chk("wb_regWrite", 32'(o_regWrite), 32'(e.rw));
          chk("wb_write_reg", 32'(o_write_reg), 32'(e.wr));
          chk("wb_alu_result", o_alu_result, e.alu);
          chk("wb_read_data", o_read_data, e.rd);
        end
      end
      prev_wb = cur_wb;
    end
  end

  function automatic wb_t mk(input logic m2r, input logic rw, input logic [4:0] wr,
                             input logic [31:0] alu, input logic [31:0] rd);
    mk = {m2r, rw, wr, alu, rd};
  endfunction

  // Called at a negedge; returns at the negedge after the op leaves the stage.
  task automatic run_op(input logic rd_i, input logic wr_i, input logic m2r_i, input logic rw_i,
                        input logic [1:0] w_i, input logic s_i, input logic [4:0] dst_i,
                        input logic [31:0] a_i, input logic [31:0] d_i, input logic [31:0] rdata_i,
                        input int waits, input logic halt_busy,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd,
                        input int exp_stall, input int exp_lat);
    int   busy   = 0;
    int   stalls = 0;
    int   cyc    = 0;
    logic st     = 1'b1;
    logic seen   = 1'b0;
    i_memRead = rd_i; i_memWrite = wr_i; i_mem2reg = m2r_i; i_regWrite = rw_i;
    i_width = w_i; i_sign_flag = s_i; i_write_reg = dst_i; i_result = a_i;
    i_data4Mem = d_i; i_halt = 1'b0;
    while (st && cyc < 20) begin
      if (dm.req) begin
        if (!seen) begin
          seen = 1'b1;
          chk("dm_addr", dm.addr, a_i & 32'hFFFF_FFFC);
          chk("dm_we", 32'(dm.we), 32'(wr_i));
          if (wr_i) begin
            chk("dm_be", 32'(dm.be), 32'(exp_be));
            chk("dm_wdata", dm.wdata, exp_wd);
          end
        end
        if (halt_busy) i_halt = 1'b1;
        if (busy == waits) begin
          dm.ack = 1'b1;
          dm.rdata = rdata_i;
        end
        busy++;
      end
      #1;
      st = o_stall;
      if (st) stalls++;
      @(negedge clk);
      dm.ack = 1'b0;
      dm.rdata = '0;
      cyc++;
    end
    if (st) begin
      checks++;
      failures++;
      $display("FAIL op_timeout actual=stalled required=done");
    end
    chk("stall_cycles", 32'(stalls), 32'(exp_stall));
    chk("latency", 32'(cyc), 32'(exp_lat));
    if (exp_stall == 0) chk("no_request", 32'(seen), 32'd0);
    i_halt = 1'b1; i_memRead = 1'b0; i_memWrite = 1'b0;
  endtask

  initial begin
    i_rst_n = 1'b0; i_halt = 1'b0; i_mem2reg = 1'b0; i_memRead = 1'b0;
    i_memWrite = 1'b0; i_regWrite = 1'b0; i_width = 2'b00; i_sign_flag = 1'b0;
    i_write_reg = '0; i_result = '0; i_data4Mem = '0;
    dm.ack = 1'b0; dm.rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(dm.req), 32'd0);
    chk("rst_we", 32'(dm.we), 32'd0);
    chk("rst_addr", dm.addr, 32'd0);
    chk("rst_be", 32'(dm.be), 32'd0);
    chk("rst_wdata", dm.wdata, 32'd0);
    chk("rst_stall", 32'(o_stall), 32'd0);
    chk("rst_wb", 32'(cur_wb != '0), 32'd0);
    i_rst_n = 1'b1;
    i_halt  = 1'b1;
    @(negedge clk);

    // ALU pass-through
    exp_q.push_back(mk(1'b0, 1'b1, 5'd5, 32'h0000_1234, 32'h0));
    run_op(0, 0, 0, 1, WIDTH_WORD, 0, 5'd5, 32'h1234, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 0, 1);

    // sb with two wait cycles
    exp_q.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0000_0103, 32'h0));
    run_op(0, 1, 0, 0, WIDTH_BYTE, 0, 5'd0, 32'h103, 32'hAB, 32'h0, 2, 0,
           4'b1000, 32'hABAB_ABAB, 3, 4);

    // halt blocks launch of a pending load
    i_memRead = 1'b1; i_width = WIDTH_WORD; i_result = 32'h700;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("halt_stall", 32'(o_stall), 32'd0);
      chk("halt_req", 32'(dm.req), 32'd0);
      @(negedge clk);
    end
    i_memRead = 1'b0;

    // lh upper half, sign and zero extension
    exp_q.push_back(mk(1'b1, 1'b1, 5'd8, 32'h0000_0202, 32'hFFFF_8001));
    run_op(1, 0, 1, 1, WIDTH_HALF, 1, 5'd8, 32'h202, 32'h0, 32'h8001_7FFF, 1, 0, 4'h0, 32'h0, 2, 3);
    exp_q.push_back(mk(1'b1, 1'b1, 5'd9, 32'h0000_0202, 32'h0000_8001));
    run_op(1, 0, 1, 1, WIDTH_HALF, 0, 5'd9, 32'h202, 32'h0, 32'h8001_7FFF, 0, 1, 4'h0, 32'h0, 1, 2);

    // lw zero-wait
    exp_q.push_back(mk(1'b1, 1'b1, 5'd10, 32'h0000_0300, 32'hDEAD_BEEF));
    run_op(1, 0, 1, 1, WIDTH_WORD, 0, 5'd10, 32'h300, 32'h0, 32'hDEAD_BEEF, 0, 0, 4'h0, 32'h0, 1, 2);

    // sh upper half, lb signed, lbu, sw
    exp_q.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0000_0012, 32'h0));
    run_op(0, 1, 0, 0, WIDTH_HALF, 0, 5'd0, 32'h12, 32'h1234_5678, 32'h0, 1, 0,
           4'b1100, 32'h5678_5678, 2, 3);
    exp_q.push_back(mk(1'b1, 1'b1, 5'd11, 32'h0000_0401, 32'hFFFF_FF83));
    run_op(1, 0, 1, 1, WIDTH_BYTE, 1, 5'd11, 32'h401, 32'h0, 32'h1122_8344, 0, 0, 4'h0, 32'h0, 1, 2);
    exp_q.push_back(mk(1'b1, 1'b1, 5'd12, 32'h0000_0402, 32'h0000_0022));
    run_op(1, 0, 1, 1, WIDTH_BYTE, 0, 5'd12, 32'h402, 32'h0, 32'h1122_8344, 0, 0, 4'h0, 32'h0, 1, 2);
    exp_q.push_back(mk(1'b0, 1'b0, 5'd0, 32'h0000_0500, 32'h0));
    run_op(1, 1, 0, 0, WIDTH_WORD, 0, 5'd0, 32'h500, 32'hCAFE_F00D, 32'h0, 0, 0,
           4'b1111, 32'hCAFE_F00D, 1, 2);

`ifdef MEM_MISALIGN_TRAP_EN
    exp_q.push_back(mk(1'b1, 1'b0, 5'd3, 32'h0000_0102, 32'h0));
    run_op(1, 0, 1, 1, WIDTH_WORD, 0, 5'd3, 32'h102, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 0, 1);
    chk("misaligned_pulse", 32'(o_misaligned), 32'd1);
    @(negedge clk);
    chk("misaligned_clear", 32'(o_misaligned), 32'd0);
`else
    exp_q.push_back(mk(1'b1, 1'b1, 5'd13, 32'h0000_0303, 32'h0102_0304));
    run_op(1, 0, 1, 1, WIDTH_WORD, 0, 5'd13, 32'h303, 32'h0, 32'h0102_0304, 0, 0, 4'h0, 32'h0, 1, 2);
`endif

    // asynchronous reset while BUSY
    i_memRead = 1'b1; i_mem2reg = 1'b1; i_regWrite = 1'b1; i_width = WIDTH_WORD;
    i_write_reg = 5'd14; i_result = 32'h600; i_halt = 1'b0;
    @(negedge clk);
    chk("busy_req", 32'(dm.req), 32'd1);
    #2 i_rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(dm.req), 32'd0);
    chk("arst_regWrite", 32'(o_regWrite), 32'd0);
    chk("arst_alu_result", o_alu_result, 32'd0);
    chk("arst_wb", 32'(cur_wb != '0), 32'd0);
    i_memRead = 1'b0; i_halt = 1'b1;
    @(negedge clk);
    @(negedge clk);
    i_rst_n = 1'b1;
    @(negedge clk);
    exp_q.push_back(mk(1'b1, 1'b1, 5'd15, 32'h0000_0604, 32'hA5A5_5A5A));
    run_op(1, 0, 1, 1, WIDTH_WORD, 0, 5'd15, 32'h604, 32'h0, 32'hA5A5_5A5A, 1, 0, 4'h0, 32'h0, 2, 3);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
